uart_tx_arbiter: RTL

Shares one UART transmitter between NUM_REQ byte-producing requesters. It arbitrates round-robin and captures the winner's byte. It then launches the frame with a one-cycle DATA_VALID pulse, holds P_DATA stable and tracks the transmitter's Busy line until the frame completes. It sits directly in front of the UART TX top (FSM + serializer + parity + mux) and is the only driver of its DATA_VALID / P_DATA inputs.

---
 rtl/uart_tx_arb_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/uart_tx_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/uart_tx_arb_pkg.sv
// rtl/uart_tx_arb_pkg.sv - shared types, defaults and width helper for the UART TX arbiter
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    LAUNCH  = 2'b01,
    WAIT_HI = 2'b11,
    WAIT_LO = 2'b10
  } arb_state_e;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_BUSY_TIMEOUT = 4;

  // Index width that never collapses to zero bits for a single requester
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a supplied pointer
module rr_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int  NUM_REQ = DEF_NUM_REQ,
  localparam int IDW     = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     pointer,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx,
  output logic               any_grant
);

  int idx;

  // Scan pointer, pointer+1, ... with wrap; the first set request wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(pointer) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (enable && !any_grant && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = IDW'(idx);
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART transmitter between byte requesters
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int  NUM_REQ      = DEF_NUM_REQ,
  parameter int  DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int  BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
  localparam int IDW          = clog2_min1(NUM_REQ)
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_data_valid,
  output logic [DATA_WIDTH-1:0]         tx_p_data,
  input  logic                          tx_busy,
  output logic [IDW-1:0]                grant_id,
  output logic                          frame_done,
  output logic                          tx_timeout
);

  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  arb_state_e            state_q, state_d;
  logic [IDW-1:0]        ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic [IDW-1:0]        gid_q, gid_d;
  logic                  dv_q, dv_d;
  logic                  done_q, done_d;
  logic                  to_q, to_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [NUM_REQ-1:0]    arb_grant;
  logic [IDW-1:0]        arb_idx;
  logic                  arb_any;
  logic [CW-1:0]         cnt_inc;
  logic                  busy_expired;

  // Arbitration only runs while idle, which keeps at most one frame in flight
  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req       (req_valid),
    .pointer   (ptr_q),
    .enable    (state_q == IDLE),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_grant (arb_any)
  );

  assign req_ready     = arb_grant;
  assign cnt_inc       = cnt_q + CW'(1);
  assign busy_expired  = (cnt_inc == CW'(BUSY_TIMEOUT));

  assign tx_data_valid = dv_q;
  assign tx_p_data     = p_data_q;
  assign grant_id      = gid_q;
  assign frame_done    = done_q;
  assign tx_timeout    = to_q;

  // State and datapath registers; reset drops any captured byte immediately
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      p_data_q <= '0;
      gid_q    <= '0;
      dv_q     <= 1'b0;
      done_q   <= 1'b0;
      to_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      p_data_q <= p_data_d;
      gid_q    <= gid_d;
      dv_q     <= dv_d;
      done_q   <= done_d;
      to_q     <= to_d;
      cnt_q    <= cnt_d;
    end
  end

  // Frame sequencing: accept, one launch cycle, wait for busy to rise, then fall
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_any) state_d = LAUNCH;
      LAUNCH:  state_d = WAIT_HI;
      WAIT_HI: begin
        if (tx_busy) begin
          state_d = WAIT_LO;
        end else if (busy_expired) begin
          state_d = IDLE;
        end
      end
      WAIT_LO: if (!tx_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture on accept, single-cycle pulses, busy-rise watchdog counter
  always_comb begin
    ptr_d    = ptr_q;
    p_data_d = p_data_q;
    gid_d    = gid_q;
    dv_d     = 1'b0;
    done_d   = 1'b0;
    to_d     = 1'b0;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          p_data_d = req_data[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
          gid_d    = arb_idx;
          ptr_d    = (arb_idx == IDW'(NUM_REQ - 1)) ? '0 : arb_idx + IDW'(1);
          dv_d     = 1'b1;
        end
      end
      LAUNCH: cnt_d = '0;
      WAIT_HI: begin
        if (!tx_busy) begin
          cnt_d = cnt_inc;
          to_d  = busy_expired;
        end
      end
      WAIT_LO: done_d = !tx_busy;
      default: ;
    endcase
  end

endmodule
